monitor_initiator: RTL

Host-side initiator for the 3-byte UART monitor protocol: `addr_hi`, `addr_lo`, then `{op[1:0], count[5:0]}`. It accepts one command from local logic and drives the byte-level UART core's transmit side. For each byte sent it checks the responder's echo, then moves the payload: it transmits bytes for LOAD, collects bytes for DUMP, and collects one status byte for EXEC. It sits between a sequencer (boot loader, test driver) and a `uart` instance wired to the target board's monitor.

---
 rtl/monitor_pkg.sv | 48 ++++
 rtl/monitor_timeout.sv | 36 +++
 rtl/monitor_initiator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/monitor_pkg.sv
// Shared definitions for the UART monitor protocol initiator.
// Op codes, error codes, FSM states and the 3-byte header layout.
package monitor_pkg;

  localparam logic [1:0] OP_BAD  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_DUMP = 2'd2;
  localparam logic [1:0] OP_EXEC = 2'd3;

  localparam logic [1:0] ERR_BADOP    = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_RXERR    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_TX,
    S_HDR_ECHO,
    S_PL_TX,
    S_PL_ECHO,
    S_RX_DATA,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] count;
  } hdr_t;

  function automatic logic [7:0] hdr_byte(
    input logic [1:0]  idx,
    input logic [15:0] addr,
    input logic [1:0]  op,
    input logic [5:0]  count
  );
    hdr_t       h;
    logic [7:0] b;
    h.op    = op;
    h.count = count;
    unique case (1'b1)
      (idx == 2'd0): b = addr[15:8];
      (idx == 2'd1): b = addr[7:0];
      default:       b = h;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/monitor_timeout.sv
// Loadable down-counter flagging expiry while a responder byte is awaited.
// Only instantiated when MONITOR_TIMEOUT_EN is defined.
module monitor_timeout
  import monitor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] load_val,
  input  logic        load,
  input  logic        dec,
  output logic        expired
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = dec & (cnt_q == 16'd0);

endmodule

// File: rtl/monitor_initiator.sv
// Host-side initiator for the 3-byte UART monitor protocol.
// Define MONITOR_TIMEOUT_EN to abort after TIMEOUT_CYCLES silent cycles.
module monitor_initiator
  import monitor_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [5:0]  cmd_count,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        uart_transmit,
  output logic [7:0]  uart_tx_byte,
  input  logic        uart_is_transmitting,
  input  logic        uart_received,
  input  logic [7:0]  uart_rx_byte,
  input  logic        uart_recv_error,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  op_q, op_d;
  logic [5:0]  count_q, count_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [5:0]  rem_q, rem_d;
  logic [7:0]  sent_q, sent_d;
  logic        error_q, error_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        done_q, done_d;
  logic        waiting;
  logic        to_expired;
  logic [7:0]  hdr_cur;

  assign waiting = (state_q == S_HDR_ECHO) |
                   (state_q == S_PL_ECHO)  |
                   (state_q == S_RX_DATA);

  assign hdr_cur = hdr_byte(hdr_idx_q, addr_q, op_q, count_q);

`ifdef MONITOR_TIMEOUT_EN
  logic to_load;

  // Restart on every state change and every responder byte.
  assign to_load = (state_d != state_q) | uart_received;

  monitor_timeout u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_val (TIMEOUT_CYCLES - 16'd1),
    .load     (to_load),
    .dec      (waiting),
    .expired  (to_expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign to_expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    op_d          = op_q;
    count_d       = count_q;
    hdr_idx_d     = hdr_idx_q;
    rem_d         = rem_q;
    sent_d        = sent_q;
    error_d       = error_q;
    err_code_d    = err_code_q;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    cmd_ready     = 1'b0;
    wr_ready      = 1'b0;
    uart_transmit = 1'b0;
    uart_tx_byte  = 8'd0;

    if (waiting && uart_recv_error) begin
      state_d    = S_FINISH;
      error_d    = 1'b1;
      err_code_d = ERR_RXERR;
    end else if (waiting && to_expired && !uart_received) begin
      state_d    = S_FINISH;
      error_d    = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            addr_d     = cmd_addr;
            op_d       = cmd_op;
            count_d    = cmd_count;
            hdr_idx_d  = 2'd0;
            error_d    = 1'b0;
            err_code_d = 2'd0;
            if (cmd_op == OP_BAD) begin
              state_d    = S_FINISH;
              error_d    = 1'b1;
              err_code_d = ERR_BADOP;
            end else begin
              state_d = S_HDR_TX;
            end
          end
        end
        S_HDR_TX: begin
          if (!uart_is_transmitting) begin
            uart_transmit = 1'b1;
            uart_tx_byte  = hdr_cur;
            sent_d        = hdr_cur;
            state_d       = S_HDR_ECHO;
          end
        end
        S_HDR_ECHO: begin
          if (uart_received) begin
            if (uart_rx_byte != sent_q) begin
              state_d    = S_FINISH;
              error_d    = 1'b1;
              err_code_d = ERR_MISMATCH;
            end else if (hdr_idx_q != 2'd2) begin
              hdr_idx_d = hdr_idx_q + 2'd1;
              state_d   = S_HDR_TX;
            end else if (op_q == OP_EXEC) begin
              rem_d   = 6'd1;
              state_d = S_RX_DATA;
            end else begin
              rem_d = count_q;
              if (count_q == 6'd0) begin
                state_d = S_FINISH;
              end else if (op_q == OP_LOAD) begin
                state_d = S_PL_TX;
              end else begin
                state_d = S_RX_DATA;
              end
            end
          end
        end
        S_PL_TX: begin
          wr_ready = !uart_is_transmitting;
          if (wr_valid && !uart_is_transmitting) begin
            uart_transmit = 1'b1;
            uart_tx_byte  = wr_data;
            sent_d        = wr_data;
            state_d       = S_PL_ECHO;
          end
        end
        S_PL_ECHO: begin
          if (uart_received) begin
            if (uart_rx_byte != sent_q) begin
              state_d    = S_FINISH;
              error_d    = 1'b1;
              err_code_d = ERR_MISMATCH;
            end else begin
              rem_d   = rem_q - 6'd1;
              state_d = (rem_q == 6'd1) ? S_FINISH : S_PL_TX;
            end
          end
        end
        S_RX_DATA: begin
          if (uart_received) begin
            rd_valid_d = 1'b1;
            rd_data_d  = uart_rx_byte;
            rem_d      = rem_q - 6'd1;
            if (rem_q == 6'd1) begin
              state_d = S_FINISH;
            end
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'd0;
      op_q       <= 2'd0;
      count_q    <= 6'd0;
      hdr_idx_q  <= 2'd0;
      rem_q      <= 6'd0;
      sent_q     <= 8'd0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      count_q    <= count_d;
      hdr_idx_q  <= hdr_idx_d;
      rem_q      <= rem_d;
      sent_q     <= sent_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_code_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
